// File: rtl/swap_request_sequencer.sv
// Upstream sequencer for the 3-register rotate/swap controller: queues host requests, issues one
// start pulse per request, waits for swap_done. Optional macro SWAP_SEQ_RETRY_EN: one re-issue on first timeout.
module swap_request_sequencer #(
  parameter int unsigned MAX_PENDING = 7,
  parameter int unsigned CNT_W       = 3,
  parameter int unsigned TIMEOUT     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             start,
  input  logic             swap_done,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic [7:0]       completed,
  output logic             timeout_err
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  localparam logic [CNT_W-1:0] MAX_P    = CNT_W'(MAX_PENDING);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic [7:0]       completed_q, completed_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             err_q, err_d;
  logic             accept, dequeue;
`ifdef SWAP_SEQ_RETRY_EN
  logic             retry_q, retry_d;
`endif

  assign req_ready   = (pending_q < MAX_P) && (state_q != ST_ERR);
  assign accept      = req_valid && req_ready;
  assign start       = (state_q == ST_START);
  assign busy        = (state_q == ST_START) || (state_q == ST_WAIT);
  assign pending     = pending_q;
  assign completed   = completed_q;
  assign timeout_err = err_q;

  always_comb begin
    state_d     = state_q;
    completed_d = completed_q;
    timer_d     = timer_q;
    err_d       = err_q;
    dequeue     = 1'b0;
`ifdef SWAP_SEQ_RETRY_EN
    retry_d     = retry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pending_q != '0) begin
          dequeue = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (swap_done) begin
          state_d     = ST_IDLE;
          completed_d = completed_q + 8'd1;
`ifdef SWAP_SEQ_RETRY_EN
          retry_d     = 1'b0;
`endif
        end else if (timer_q == TMR_LAST) begin
`ifdef SWAP_SEQ_RETRY_EN
          // First timeout of this request re-issues it; the second one is fatal.
          if (!retry_q) begin
            retry_d = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
`else
          state_d = ST_ERR;
          err_d   = 1'b1;
`endif
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: ;
    endcase

    pending_d = pending_q;
    if (accept && !dequeue)      pending_d = pending_q + CNT_W'(1);
    else if (!accept && dequeue) pending_d = pending_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      completed_q <= '0;
      timer_q     <= '0;
      err_q       <= 1'b0;
`ifdef SWAP_SEQ_RETRY_EN
      retry_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      completed_q <= completed_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
`ifdef SWAP_SEQ_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

endmodule
